fa: RTL and testbench
=====================

// Module: fa
// PURPOSE
//   Full adder: a + b + cin -> {cout, s}, WIDTH-bit ripple-carry.
//   Arithmetic leaf cell for adders, counters and ALU datapaths.
//   Default build (WIDTH=1, REG_OUT=0) is the classic 1-bit combinational full adder.
//   An optional output register stage uses the single clock and its reset.
// PARAMETERS
//   WIDTH    1  operand width in bits; must be >= 1
//   REG_OUT  0  0 = outputs combinational; 1 = outputs registered on clk (latency 1)
// PORTS
//   clk   in   1      single clock; used only when REG_OUT=1
//   rst   in   1      synchronous, active-high reset; used only when REG_OUT=1
//   a     in   WIDTH  operand A, unsigned
//   b     in   WIDTH  operand B, unsigned
//   cin   in   1      carry in to bit 0
//   s     out  WIDTH  sum bits
//   cout  out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   - Arithmetic: {cout, s} = a + b + cin, computed at WIDTH+1 bits. No overflow is lost.
//   - Per-bit equations for bit i:
//     - s[i] = a[i] ^ b[i] ^ c[i]
//     - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
//     - c[0] = cin; cout = c[WIDTH].
//   - REG_OUT=0:
//     - Purely combinational; zero latency; no state.
//     - clk and rst are ignored; s/cout have no reset value.
//     - Outputs settle within one propagation delay of any input change.
//   - REG_OUT=1:
//     - s and cout are registered on the rising edge of clk; latency 1 cycle.
//     - New operands may be applied every cycle; no stall.
//     - The registers sample a fresh sum every cycle.
//   - Reset (REG_OUT=1):
//     - rst high at a rising edge forces s = 0 and cout = 0 on that edge.
//     - rst overrides the sum computed in that cycle.
//     - Deassertion takes effect at the next edge with rst low; the first result is valid one cycle later.
//     - Reset mid-stream discards the in-flight result; nothing is replayed.
//   - Boundary cases:
//     - All-ones + all-ones + cin=1 gives s = all-ones, cout = 1.
//     - All-zero inputs give all-zero outputs.
//   - X/Z inputs are not sanitised; they propagate to the outputs.
// STRUCTURE
//   - No shared package is needed; there are no typedefs or global constants.
//   - Sub-module fa_bit: 1-bit combinational cell (a, b, ci -> s, co).
//   - fa chains WIDTH instances of fa_bit via a generate loop (ripple carry).
//   - fa adds the optional output register under generate on REG_OUT.
// TESTING
//   1. WIDTH=1, REG_OUT=0: sweep all 8 {a,b,cin} codes with 100 ns spacing.
//      Expect {cout,s}:
//      - 000->00, 001->01, 010->01, 011->10
//      - 100->01, 101->10, 110->10, 111->11
//   2. WIDTH=1: hold a=1, b=1, cin=1 for two consecutive steps -> s=1, cout=1 stable, no glitch.
//   3. WIDTH=8, REG_OUT=0:
//      - a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1
//      - a=8'hFF, b=8'hFF, cin=1 -> s=8'hFF, cout=1
//   4. WIDTH=8, REG_OUT=1:
//      - rst=1 for 2 cycles -> s=0, cout=0.
//      - Release rst, then apply a=8'h3C, b=8'h44, cin=1 -> next edge s=8'h81, cout=0.
//   5. WIDTH=8, REG_OUT=1: assert rst while a=8'hF0, b=8'h20 is applied.
//      - Next edge: s=0, cout=0, not 8'h10/1.
//      - After release: 8'h10/1 appears one cycle later.
//   6. Random: 1000 random a/b/cin at WIDTH=1, 8 and 16 against a behavioural a+b+cin model.
//      - Zero mismatches; REG_OUT=1 runs are compared one cycle delayed.

Source files
------------

// File: rtl/fa_bit.sv
// One-bit full adder cell: the leaf of the ripple-carry chain in fa.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // The propagate term is shared by the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/fa.sv
// WIDTH-bit ripple-carry adder {cout, s} = a + b + cin, with an optional
// output register stage (REG_OUT=1) on clk and synchronous active-high rst.
module fa #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_bit u_bit (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        // Reset wins over the sum computed in the same cycle; nothing is replayed.
        always_ff @(posedge clk) begin
            if (rst) begin
                s    <= '0;
                cout <= 1'b0;
            end else begin
                s    <= sum;
                cout <= c[WIDTH];
            end
        end
    end else begin : g_comb
        // clk and rst have no function in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign s    = sum;
        assign cout = c[WIDTH];
    end

endmodule

// File: tb/tb_fa.sv
// Self-checking bench for fa: directed cases plus random operands at widths
// 1, 8 and 16, each in combinational and registered builds.
module tb_fa;

    logic clk;
    logic rst;

    logic [0:0]  a1,  b1;  logic cin1;
    logic [7:0]  a8,  b8;  logic cin8;
    logic [15:0] a16, b16; logic cin16;

    logic [0:0]  s1c,  s1r;  logic co1c,  co1r;
    logic [7:0]  s8c,  s8r;  logic co8c,  co8r;
    logic [15:0] s16c, s16r; logic co16c, co16r;

    int n_cmp = 0;
    int n_err = 0;

    // Expected registered results, one entry per driven cycle.
    logic [1:0]  exp1_q[$];
    logic [8:0]  exp8_q[$];
    logic [16:0] exp16_q[$];

    fa #(.WIDTH(1),  .REG_OUT(1'b0)) u1c  (.clk(clk), .rst(rst), .a(a1),  .b(b1),  .cin(cin1),  .s(s1c),  .cout(co1c));
    fa #(.WIDTH(1),  .REG_OUT(1'b1)) u1r  (.clk(clk), .rst(rst), .a(a1),  .b(b1),  .cin(cin1),  .s(s1r),  .cout(co1r));
    fa #(.WIDTH(8),  .REG_OUT(1'b0)) u8c  (.clk(clk), .rst(rst), .a(a8),  .b(b8),  .cin(cin8),  .s(s8c),  .cout(co8c));
    fa #(.WIDTH(8),  .REG_OUT(1'b1)) u8r  (.clk(clk), .rst(rst), .a(a8),  .b(b8),  .cin(cin8),  .s(s8r),  .cout(co8r));
    fa #(.WIDTH(16), .REG_OUT(1'b0)) u16c (.clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .s(s16c), .cout(co16c));
    fa #(.WIDTH(16), .REG_OUT(1'b1)) u16r (.clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .s(s16r), .cout(co16r));

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_all(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        a1 = va[0:0];  b1 = vb[0:0];  cin1 = vc;
        a8 = va[7:0];  b8 = vb[7:0];  cin8 = vc;
        a16 = va;      b16 = vb;      cin16 = vc;
    endtask

    task automatic drive_rand();
        a1 = 1'($urandom_range(0, 1));  b1 = 1'($urandom_range(0, 1));  cin1 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom);              b8 = 8'($urandom);              cin8 = 1'($urandom_range(0, 1));
        a16 = 16'($urandom);            b16 = 16'($urandom);            cin16 = 1'($urandom_range(0, 1));
    endtask

    // Reference model: plain wide addition.
    function automatic logic [16:0] ref_sum(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        return 17'(va) + 17'(vb) + 17'(vc);
    endfunction

    task automatic check_comb();
        check("rand_w1_comb",  {30'd0, co1c, s1c},   {15'd0, ref_sum(16'(a1), 16'(b1), cin1)});
        check("rand_w8_comb",  {23'd0, co8c, s8c},   {15'd0, ref_sum(16'(a8), 16'(b8), cin8)});
        check("rand_w16_comb", {15'd0, co16c, s16c}, {15'd0, ref_sum(a16, b16, cin16)});
    endtask

    // Scoreboard: compare registered outputs to the entry pushed last cycle.
    task automatic check_reg();
        logic [1:0]  e1;
        logic [8:0]  e8;
        logic [16:0] e16;
        if (exp1_q.size() == 0) return;
        e1 = exp1_q.pop_front();
        e8 = exp8_q.pop_front();
        e16 = exp16_q.pop_front();
        check("rand_w1_reg",  {30'd0, co1r, s1r},   {30'd0, e1});
        check("rand_w8_reg",  {23'd0, co8r, s8r},   {23'd0, e8});
        check("rand_w16_reg", {15'd0, co16r, s16r}, {15'd0, e16});
    endtask

    task automatic push_expected();
        if (rst) begin
            exp1_q.push_back('0);
            exp8_q.push_back('0);
            exp16_q.push_back('0);
        end else begin
            exp1_q.push_back(2'(ref_sum(16'(a1), 16'(b1), cin1)));
            exp8_q.push_back(9'(ref_sum(16'(a8), 16'(b8), cin8)));
            exp16_q.push_back(ref_sum(a16, b16, cin16));
        end
    endtask

    logic [1:0] tbl1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        rst = 1'b1;
        drive_all(16'h0000, 16'h0000, 1'b0);

        // Reset held for two edges clears every registered build.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_w1",  {30'd0, co1r, s1r},   32'd0);
        check("rst_w8",  {23'd0, co8r, s8r},   32'd0);
        check("rst_w16", {15'd0, co16r, s16r}, 32'd0);

        // 1-bit truth table, 100 ns apart.
        for (int k = 0; k < 8; k++) begin
            a1 = 1'(k >> 2); b1 = 1'(k >> 1); cin1 = 1'(k);
            #100;
            check($sformatf("tt_%0d", k), {30'd0, co1c, s1c}, {30'd0, tbl1[k]});
        end

        // 1+1+1 held for two steps stays at {1,1}.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        #100;
        check("hold111_a", {30'd0, co1c, s1c}, 32'd3);
        #100;
        check("hold111_b", {30'd0, co1c, s1c}, 32'd3);

        // 8-bit combinational boundaries.
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        #1 check("w8_ff_01", {23'd0, co8c, s8c}, 32'h100);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        #1 check("w8_ff_ff_c", {23'd0, co8c, s8c}, 32'h1FF);
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        #1 check("w8_zero", {23'd0, co8c, s8c}, 32'h000);
        drive_all(16'hFFFF, 16'hFFFF, 1'b1);
        #1 check("w16_ones_c", {15'd0, co16c, s16c}, 32'h1FFFF);

        // Registered: rst held through all of the above keeps outputs at zero.
        @(negedge clk);
        check("rst_hold_w8", {23'd0, co8r, s8r}, 32'd0);

        // Release rst and apply 3C+44+1.
        rst = 1'b0;
        a8 = 8'h3C; b8 = 8'h44; cin8 = 1'b1;
        @(negedge clk);
        check("reg_3c_44", {23'd0, co8r, s8r}, 32'h081);

        // Reset overrides F0+20 in the same cycle.
        rst = 1'b1;
        a8 = 8'hF0; b8 = 8'h20; cin8 = 1'b0;
        @(negedge clk);
        check("reg_rst_override", {23'd0, co8r, s8r}, 32'h000);
        rst = 1'b0;
        @(negedge clk);
        check("reg_after_release", {23'd0, co8r, s8r}, 32'h110);

        // Random stream; a few cycles carry a mid-stream reset.
        exp1_q.delete(); exp8_q.delete(); exp16_q.delete();
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            check_reg();
            rst = (n == 400 || n == 401 || n == 777);
            drive_rand();
            push_expected();
            #1 check_comb();
        end
        @(negedge clk);
        check_reg();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
